// File: rtl/micro_alpha_veryl_alu_multicycle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : micro_alpha_veryl_package_alu_multicycle
// Brief    : Operation and FSM state encodings for the multicycle ALU.
// Revision : 1.0 - initial release
// ============================================================================
package micro_alpha_veryl_package_alu_multicycle;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_MUL = 4'd8
    } alu_mc_operation_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_mc_state_t;

endpackage
`default_nettype wire

// File: rtl/micro_alpha_veryl_alu_mc_datapath.sv
`default_nettype none
// ============================================================================
// Module   : micro_alpha_veryl_alu_mc_datapath
// Brief    : Single-cycle combinational operations of the multicycle ALU.
// Revision : 1.0 - initial release
// ============================================================================
module micro_alpha_veryl_alu_mc_datapath
    import micro_alpha_veryl_package_alu_multicycle::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    always_comb begin
        result = '1;
        cout   = 1'b0;
        w_sum  = '0;
        w_diff = '0;
        case (operation)
            OP_ADD: begin
                w_sum  = {1'b0, left} + {1'b0, right} + (WIDTH+1)'(cin);
                result = w_sum[WIDTH-1:0];
                cout   = w_sum[WIDTH];
            end
            OP_SUB: begin
                // Bit WIDTH of the extended difference is set exactly when it went negative
                w_diff = {1'b0, left} - {1'b0, right} - (WIDTH+1)'(cin);
                result = w_diff[WIDTH-1:0];
                cout   = w_diff[WIDTH];
            end
            OP_AND: result = left & right;
            OP_OR:  result = left | right;
            OP_XOR: result = left ^ right;
            // Zero-amount shifts complete here and simply pass the operand through
            OP_SHL, OP_SHR: result = left;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/micro_alpha_veryl_alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : micro_alpha_veryl_alu_multicycle
// Brief    : Valid/ready ALU with iterative shifts and shift-add multiply.
// Revision : 1.0 - initial release
// ============================================================================
module micro_alpha_veryl_alu_multicycle
    import micro_alpha_veryl_package_alu_multicycle::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int C_AMT_W = $clog2(WIDTH);
    localparam int C_CNT_W = C_AMT_W + 1;

    alu_mc_state_t      r_state;
    alu_mc_state_t      w_state_next;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_is_mul;
    logic               r_is_shl;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_result;
    logic               r_cout;

    logic [C_AMT_W-1:0] w_amt;
    logic               w_is_mul;
    logic               w_is_shift;
    logic               w_goes_busy;
    logic               w_last;
    logic [WIDTH-1:0]   w_dp_result;
    logic               w_dp_cout;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_mul_hi;
    logic [WIDTH-1:0]   w_mul_lo;
    logic [WIDTH-1:0]   w_sh_lo;
    logic               w_sh_out;

    micro_alpha_veryl_alu_mc_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .operation (operation),
        .left      (left),
        .right     (right),
        .cin       (cin),
        .result    (w_dp_result),
        .cout      (w_dp_cout)
    );

    assign w_amt       = right[C_AMT_W-1:0];
    assign w_is_mul    = (operation == OP_MUL);
    assign w_is_shift  = (operation == OP_SHL) || (operation == OP_SHR);
    assign w_goes_busy = w_is_mul || (w_is_shift && (w_amt != '0));
    assign w_last      = (r_cnt == C_CNT_W'(1));

    // Multiply step: {hi,lo} holds partial product over the remaining multiplier bits
    assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    assign w_mul_hi = w_sum[WIDTH:1];
    assign w_mul_lo = {w_sum[0], r_lo[WIDTH-1:1]};

    assign w_sh_lo  = r_is_shl ? {r_lo[WIDTH-2:0], 1'b0} : {1'b0, r_lo[WIDTH-1:1]};
    assign w_sh_out = r_is_shl ? r_lo[WIDTH-1] : r_lo[0];

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign cout      = r_cout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_state_next = w_goes_busy ? ST_BUSY : ST_DONE;
            ST_BUSY: if (w_last)   w_state_next = ST_DONE;
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_is_mul <= 1'b0;
            r_is_shl <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_mcand  <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_is_mul <= w_is_mul;
                        r_is_shl <= (operation == OP_SHL);
                        r_hi     <= '0;
                        r_mcand  <= left;
                        if (w_is_mul) begin
                            r_lo  <= right;
                            r_cnt <= C_CNT_W'(WIDTH);
                        end else begin
                            r_lo  <= left;
                            r_cnt <= {1'b0, w_amt};
                        end
                        if (!w_goes_busy) begin
                            r_result <= w_dp_result;
                            r_cout   <= w_dp_cout;
                        end
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - C_CNT_W'(1);
                    if (r_is_mul) begin
                        r_hi <= w_mul_hi;
                        r_lo <= w_mul_lo;
                        if (w_last) begin
                            r_result <= w_mul_lo;
                            r_cout   <= |w_mul_hi;
                        end
                    end else begin
                        r_lo <= w_sh_lo;
                        if (w_last) begin
                            r_result <= w_sh_lo;
                            r_cout   <= w_sh_out;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
